// File: rtl/autosym_eval_if.sv
// Stream and configuration bundle for autosym_eval.
// The master drives the input stream, output acceptance and config writes; the slave is the evaluator.
interface autosym_eval_if #(
  parameter int N_IN  = 8,
  parameter int K     = 4,
  parameter int CNT_W = 16
);
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN-1:0]      in_x;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_y;
  logic [K-1:0]         out_z;
  logic                 cfg_row_we;
  logic [IDX_W-1:0]     cfg_row_idx;
  logic [N_IN-1:0]      cfg_row_data;
  logic                 cfg_tt_we;
  logic [(1<<K)-1:0]    cfg_tt_data;
  logic                 cfg_busy;
  logic                 cfg_err;
  logic [CNT_W-1:0]     ones_cnt;

  modport master (
    output in_valid, in_x, out_ready,
           cfg_row_we, cfg_row_idx, cfg_row_data, cfg_tt_we, cfg_tt_data,
    input  in_ready, out_valid, out_y, out_z, cfg_busy, cfg_err, ones_cnt
  );

  modport slave (
    input  in_valid, in_x, out_ready,
           cfg_row_we, cfg_row_idx, cfg_row_data, cfg_tt_we, cfg_tt_data,
    output in_ready, out_valid, out_y, out_z, cfg_busy, cfg_err, ones_cnt
  );
endinterface

// File: rtl/autosym_eval.sv
// Evaluates f(x) = tt[z], where z is a GF(2) linear projection of x given by K row masks.
// Two-stage valid/ready pipeline; configuration may only change while the pipeline is empty.
module autosym_eval #(
  parameter int N_IN  = 8,
  parameter int K     = 4,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  autosym_eval_if.slave bus
);
  localparam int TT_W = 1 << K;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_IN-1:0]  row [K];
  logic [TT_W-1:0]  tt;

  logic             s1_valid;
  logic [K-1:0]     s1_z;
  logic             s2_valid;
  logic             s2_y;
  logic [K-1:0]     s2_z;
  logic             cfg_err_q;
  logic [CNT_W-1:0] ones_q;

  logic             s1_adv, s2_adv, accept, deliver, busy;
  logic             idx_ok, row_wr, tt_wr, wr_rej;
  logic [N_IN-1:0]  row_eff [K];
  logic [K-1:0]     z_next;

  assign busy    = s1_valid | s2_valid;
  assign deliver = s2_valid & bus.out_ready;
  assign s2_adv  = ~s2_valid | bus.out_ready;
  assign s1_adv  = ~s1_valid | s2_adv;
  assign accept  = bus.in_valid & bus.in_ready;

  assign idx_ok  = int'(bus.cfg_row_idx) < K;
  assign row_wr  = bus.cfg_row_we & ~busy & idx_ok;
  assign tt_wr   = bus.cfg_tt_we & ~busy;
  assign wr_rej  = (bus.cfg_row_we & (busy | ~idx_ok)) | (bus.cfg_tt_we & busy);

  // An input accepted on the same edge as a row write must see the new row, so project
  // through the pending write data. The table needs no bypass: it is read one edge later.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      row_eff[i] = (row_wr && int'(bus.cfg_row_idx) == i) ? bus.cfg_row_data : row[i];
      z_next[i]  = ^(bus.in_x & row_eff[i]);
    end
  end

  // NOTE: the row masks and truth table are small flop arrays with defined reset contents
  // (identity projection, zero table), so they sit in the reset branch like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_z      <= '0;
      s2_valid  <= 1'b0;
      s2_y      <= 1'b0;
      s2_z      <= '0;
      cfg_err_q <= 1'b0;
      ones_q    <= '0;
      tt        <= '0;
      for (int i = 0; i < K; i++) row[i] <= N_IN'(1) << i;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_z <= s1_z;
          s2_y <= tt[s1_z];
        end
      end
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) s1_z <= z_next;
      end
      for (int i = 0; i < K; i++)
        if (row_wr && int'(bus.cfg_row_idx) == i) row[i] <= bus.cfg_row_data;
      if (tt_wr) tt <= bus.cfg_tt_data;
      if (wr_rej) cfg_err_q <= 1'b1;
      if (deliver && s2_y && ones_q != CNT_MAX) ones_q <= ones_q + 1'b1;
    end
  end

  // in_ready is forced low during reset so nothing is accepted while state is being cleared.
  assign bus.in_ready  = ~rst & s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_y     = s2_y;
  assign bus.out_z     = s2_z;
  assign bus.cfg_busy  = busy;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.ones_cnt  = ones_q;
endmodule

// File: tb/tb_autosym_eval.sv
// Randomized and directed bench for autosym_eval against a transaction-level model:
// a queue of accepted items, each stamped with its acceptance cycle and expected result.
module tb_autosym_eval;
  localparam int N_IN  = 8;
  localparam int K     = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  autosym_eval_if #(.N_IN(N_IN), .K(K), .CNT_W(CNT_W)) bus ();

  autosym_eval #(.N_IN(N_IN), .K(K), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [K-1:0] z;
    logic         y;
    int           cyc;
  } item_t;

  item_t        q[$];
  logic [7:0]   m_row [K];
  logic [15:0]  m_tt;
  logic         m_err;
  int           m_ones;
  int           cyc;
  int           n_checks;
  int           n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // z bit i is the parity of the bits of x selected by row i.
  function automatic logic [K-1:0] project(input logic [7:0] x);
    logic [K-1:0] z;
    for (int i = 0; i < K; i++) z[i] = ($countones(x & m_row[i]) % 2) == 1;
    return z;
  endfunction

  task automatic m_reset();
    q.delete();
    for (int i = 0; i < K; i++) m_row[i] = 8'(1) << i;
    m_tt   = '0;
    m_err  = 1'b0;
    m_ones = 0;
  endtask

  // Called just after a falling edge with inputs already driven; checks, updates the model
  // for the coming rising edge, and returns at the next falling edge.
  task automatic tick(output bit acc);
    bit    fv, dlv, busy, rdy;
    item_t it;
    #1;
    fv   = q.size() > 0 && (cyc - q[0].cyc) >= 2;
    busy = q.size() > 0;
    rdy  = q.size() < 2 || (fv && bus.out_ready);
    check("in_ready", bus.in_ready, rdy);
    check("out_valid", bus.out_valid, fv);
    if (fv) begin
      check("out_z", bus.out_z, q[0].z);
      check("out_y", bus.out_y, q[0].y);
    end
    check("cfg_busy", bus.cfg_busy, busy);
    check("cfg_err", bus.cfg_err, m_err);
    check("ones_cnt", bus.ones_cnt, m_ones);
    dlv = fv && bus.out_ready;
    acc = bus.in_valid && rdy;
    if (bus.cfg_row_we) begin
      if (busy || int'(bus.cfg_row_idx) >= K) m_err = 1'b1;
      else m_row[bus.cfg_row_idx] = bus.cfg_row_data;
    end
    if (bus.cfg_tt_we) begin
      if (busy) m_err = 1'b1;
      else m_tt = bus.cfg_tt_data;
    end
    if (dlv) begin
      if (q[0].y && m_ones < 65535) m_ones++;
      void'(q.pop_front());
    end
    if (acc) begin
      it.z   = project(bus.in_x);
      it.y   = m_tt[it.z];
      it.cyc = cyc;
      q.push_back(it);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    bus.cfg_row_we = 1'b0;
    bus.cfg_tt_we  = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    bus.in_valid = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic send(input logic [7:0] x);
    bit a;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    a = 1'b0;
    for (int i = 0; i < 10 && !a; i++) tick(a);
    if (!a) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.cfg_row_we   = 1'b0;
    bus.cfg_tt_we    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_z", bus.out_z, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_ones", bus.ones_cnt, 0);
    check("rst_busy", bus.cfg_busy, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int k;
    logic [7:0] xs [3];
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    bus.in_valid     = 1'b0;
    bus.in_x         = '0;
    bus.out_ready    = 1'b1;
    bus.cfg_row_we   = 1'b0;
    bus.cfg_row_idx  = '0;
    bus.cfg_row_data = '0;
    bus.cfg_tt_we    = 1'b0;
    bus.cfg_tt_data  = '0;
    m_reset();
    do_reset();

    // Table write, then a single item: result two edges after acceptance.
    bus.cfg_tt_we   = 1'b1;
    bus.cfg_tt_data = 16'h8000;
    tick(a);
    send(8'h0F);
    idle(1);
    #1;
    check("req42_valid", bus.out_valid, 1);
    check("req42_z", bus.out_z, 4'hF);
    check("req42_y", bus.out_y, 1);
    idle(1);
    #1;
    check("req42_ones", bus.ones_cnt, 1);

    // Row 0 = 0x03 makes z[0] the parity of x[1:0].
    bus.cfg_row_we   = 1'b1;
    bus.cfg_row_idx  = 2'd0;
    bus.cfg_row_data = 8'h03;
    tick(a);
    send(8'h03);
    idle(1);
    #1;
    check("req43_z0_x03", bus.out_z[0], 0);
    idle(1);
    send(8'h01);
    idle(1);
    #1;
    check("req43_z0_x01", bus.out_z[0], 1);
    idle(2);

    // Backpressure: two items held, third waits, order preserved on release.
    do_reset();
    xs[0] = 8'h01; xs[1] = 8'h02; xs[2] = 8'h03;
    bus.out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = xs[k];
      tick(a);
      if (a) k++;
    end
    #1;
    check("req44_held", k, 2);
    check("req44_ready_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && (k < 3 || q.size() > 0); i++) begin
      bus.in_valid = (k < 3);
      bus.in_x     = xs[k < 3 ? k : 2];
      tick(a);
      if (a) k++;
    end
    check("req44_all_accepted", k, 3);
    check("req44_drained", q.size(), 0);
    idle(1);

    // Config write while busy is dropped and latches the error flag.
    do_reset();
    bus.out_ready = 1'b0;
    send(8'h01);
    bus.cfg_tt_we   = 1'b1;
    bus.cfg_tt_data = 16'hFFFF;
    tick(a);
    #1;
    check("req45_err", bus.cfg_err, 1);
    bus.out_ready = 1'b1;
    idle(4);
    send(8'h0F);
    idle(3);
    #1;
    check("req45_err_sticky", bus.cfg_err, 1);

    // Random traffic with occasional config writes.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid     = $urandom_range(0, 3) != 0;
      bus.in_x         = 8'($urandom);
      bus.out_ready    = $urandom_range(0, 3) != 0;
      bus.cfg_row_we   = $urandom_range(0, 9) == 0;
      bus.cfg_row_idx  = 2'($urandom);
      bus.cfg_row_data = 8'($urandom);
      bus.cfg_tt_we    = $urandom_range(0, 9) == 0;
      bus.cfg_tt_data  = 16'($urandom);
      if (i % 40 >= 35) bus.in_valid = 1'b0;
      tick(a);
    end
    bus.out_ready = 1'b1;
    idle(4);

    // Asynchronous reset with both stages full.
    do_reset();
    bus.out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 6 && k < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 8'($urandom);
      tick(a);
      if (a) k++;
    end
    bus.in_valid = 1'b0;
    #1;
    check("req47_full_valid", bus.out_valid, 1);
    check("req47_full_busy", bus.cfg_busy, 1);
    rst = 1'b1;
    #1;
    check("req47_async_valid", bus.out_valid, 0);
    check("req47_async_busy", bus.cfg_busy, 0);
    do_reset();
    bus.out_ready = 1'b1;
    send(8'h05);
    idle(1);
    #1;
    check("req47_z", bus.out_z, 4'h5);
    check("req47_y", bus.out_y, 0);
    idle(2);

    // Saturation of the ones counter at full throughput.
    do_reset();
    bus.cfg_tt_we   = 1'b1;
    bus.cfg_tt_data = 16'hFFFF;
    tick(a);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65542; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 8'($urandom);
      tick(a);
    end
    idle(3);
    #1;
    check("req46_saturated", bus.ones_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
